// File: rtl/cpu_sm_pkg.sv
// Shared definitions for the CPU bus-cycle termination logic: the
// termination FSM state set, responding-port encodings, the default
// bus-error timeout and the timeout counter width.
package cpu_sm_pkg;

   // Termination FSM states
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_TERM  = 3'd1,
      ST_SETTLE     = 3'd2,
      ST_TERMINATED = 3'd3,
      ST_FAULT      = 3'd4
   } term_state_t;

   // Responding port width reported on PORT_SIZE
   typedef logic [1:0] port_size_t;

   localparam port_size_t PORT_NONE = 2'b00;
   localparam port_size_t PORT_8    = 2'b01;
   localparam port_size_t PORT_16   = 2'b10;
   localparam port_size_t PORT_32   = 2'b11;

   // Default number of WAIT_TERM clocks before a bus error is declared
   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

   // Width of the saturating timeout counter
   localparam int CNT_W = 8;

   // Map the active-high acknowledge pair (DSACK1, DSACK0) to a port width
   function automatic port_size_t port_from_ack(input logic ack0, input logic ack1);
      port_size_t p;
      case ({ack1, ack0})
         2'b01:   p = PORT_8;
         2'b10:   p = PORT_16;
         2'b11:   p = PORT_32;
         default: p = PORT_NONE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/cpu_sync2.sv
// Two-flop synchroniser for an asynchronous active-low bus strobe.
// Both flops reset to the deasserted level (1) so a reset never
// presents a spurious strobe to the consuming logic.
module cpu_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the raw input through two flops to settle metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cpu_term_sync.sv
// 68030 bus-cycle termination qualifier.
// Synchronises the asynchronous DSACKx_ / BERR_IN_ strobes, samples the
// synchronous STERM_IN_, and runs a small FSM that turns them into
// registered, qualified termination outputs for the CPU next-state logic.
// An 8-bit saturating counter raises a bus error when no termination
// arrives within TIMEOUT_CYCLES clocks of the cycle start.
module cpu_term_sync
   import cpu_sm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       BCLK,
   input  logic       CCRESET_,
   input  logic       DSACK0_,
   input  logic       DSACK1_,
   input  logic       STERM_IN_,
   input  logic       BERR_IN_,
   input  logic       CYCLE_START,
   input  logic       CYCLE_END,
   output logic       DSACK,
   output logic       STERM_,
   output logic [1:0] PORT_SIZE,
   output logic       BERR_,
   output logic       TIMEOUT
);

   // Counter value at which WAIT_TERM gives up and declares a fault
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   term_state_t      state;
   logic [CNT_W-1:0] tmo_cnt;

   logic dsack0_s;
   logic dsack1_s;
   logic berr_s;
   logic sterm_q;
   logic any_dsack;

   cpu_sync2 u_sync_dsack0 (
      .clk   (BCLK),
      .rst_n (CCRESET_),
      .d     (DSACK0_),
      .q     (dsack0_s)
   );

   cpu_sync2 u_sync_dsack1 (
      .clk   (BCLK),
      .rst_n (CCRESET_),
      .d     (DSACK1_),
      .q     (dsack1_s)
   );

   cpu_sync2 u_sync_berr (
      .clk   (BCLK),
      .rst_n (CCRESET_),
      .d     (BERR_IN_),
      .q     (berr_s)
   );

   // STERM_IN_ is already synchronous to BCLK, so a single sample suffices
   always_ff @(posedge BCLK or negedge CCRESET_) begin
      if (!CCRESET_) begin
         sterm_q <= 1'b1;
      end else begin
         sterm_q <= STERM_IN_;
      end
   end

   assign any_dsack = ~dsack0_s | ~dsack1_s;

   // Termination FSM with registered outputs and the saturating timeout counter
   always_ff @(posedge BCLK or negedge CCRESET_) begin
      if (!CCRESET_) begin
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         DSACK     <= 1'b0;
         STERM_    <= 1'b1;
         BERR_     <= 1'b1;
         TIMEOUT   <= 1'b0;
         PORT_SIZE <= PORT_NONE;
      end else if (state == ST_IDLE) begin
         // In IDLE a start beats a coincident end; terminations are ignored
         if (CYCLE_START) begin
            state   <= ST_WAIT_TERM;
            tmo_cnt <= '0;
         end
      end else if (CYCLE_END) begin
         // Outside IDLE the end of cycle wins and clears every output
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         DSACK     <= 1'b0;
         STERM_    <= 1'b1;
         BERR_     <= 1'b1;
         TIMEOUT   <= 1'b0;
         PORT_SIZE <= PORT_NONE;
      end else begin
         case (state)
            ST_WAIT_TERM: begin
               if (tmo_cnt != CNT_MAX) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
               if (!berr_s) begin
                  state <= ST_FAULT;
                  BERR_ <= 1'b0;
               end else if (!sterm_q) begin
                  state  <= ST_TERMINATED;
                  STERM_ <= 1'b0;
               end else if (any_dsack) begin
                  // Give the second DSACK one more clock to arrive
                  state <= ST_SETTLE;
               end else if (tmo_cnt >= TMO_LAST) begin
                  state   <= ST_FAULT;
                  BERR_   <= 1'b0;
                  TIMEOUT <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (tmo_cnt != CNT_MAX) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
               if (any_dsack) begin
                  state     <= ST_TERMINATED;
                  DSACK     <= 1'b1;
                  PORT_SIZE <= port_from_ack(~dsack0_s, ~dsack1_s);
               end else begin
                  // Acknowledge vanished: treat it as a glitch and keep waiting
                  state <= ST_WAIT_TERM;
               end
            end
            ST_TERMINATED, ST_FAULT: begin
               state <= state;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_term_sync.sv
// Self-checking bench for cpu_term_sync (TIMEOUT_CYCLES = 16).
// Inputs change 1 ns after the rising edge and outputs are observed there.
// Edge numbering: edge 0 is the edge that samples CYCLE_START; an input
// "driven at k" changes just after edge k.
module tb_cpu_term_sync;

   localparam int TMO   = 16;
   localparam int NEVER = 99;
   localparam int BIG   = 1000;
   // {DSACK, STERM_, PORT_SIZE, BERR_, TIMEOUT} when idle
   localparam logic [5:0] CLR = 6'b010010;

   logic       BCLK;
   logic       CCRESET_;
   logic       DSACK0_;
   logic       DSACK1_;
   logic       STERM_IN_;
   logic       BERR_IN_;
   logic       CYCLE_START;
   logic       CYCLE_END;
   logic       DSACK;
   logic       STERM_;
   logic [1:0] PORT_SIZE;
   logic       BERR_;
   logic       TIMEOUT;

   int total = 0;
   int bad   = 0;

   cpu_term_sync #(.TIMEOUT_CYCLES(TMO)) dut (
      .BCLK        (BCLK),
      .CCRESET_    (CCRESET_),
      .DSACK0_     (DSACK0_),
      .DSACK1_     (DSACK1_),
      .STERM_IN_   (STERM_IN_),
      .BERR_IN_    (BERR_IN_),
      .CYCLE_START (CYCLE_START),
      .CYCLE_END   (CYCLE_END),
      .DSACK       (DSACK),
      .STERM_      (STERM_),
      .PORT_SIZE   (PORT_SIZE),
      .BERR_       (BERR_),
      .TIMEOUT     (TIMEOUT)
   );

   initial BCLK = 1'b0;
   always #5 BCLK = ~BCLK;

   function automatic logic [5:0] outs();
      return {DSACK, STERM_, PORT_SIZE, BERR_, TIMEOUT};
   endfunction

   function automatic logic [5:0] mk(input logic ds, input logic st_n, input logic [1:0] ps,
                                     input logic be_n, input logic to);
      return {ds, st_n, ps, be_n, to};
   endfunction

   // Reference: which termination wins and on which edge, from the rules
   // (BERR acts 3 edges after its drive, STERM 2, DSACK enters SETTLE 3 and
   // terminates 4, timeout acts at edge TMO; ties go BERR > STERM > DSACK > timeout).
   function automatic void predict(input int db, input int ds, input int d0, input int d1,
                                   output int res_edge, output logic [5:0] res);
      int ev_b, ev_s, ev_d, dmin;
      logic a0, a1;
      ev_b = (db < NEVER) ? db + 3 : BIG;
      ev_s = (ds < NEVER) ? ds + 2 : BIG;
      dmin = (d0 < d1) ? d0 : d1;
      ev_d = (dmin < NEVER) ? dmin + 3 : BIG;
      if (ev_b <= ev_s && ev_b <= ev_d && ev_b <= TMO) begin
         res_edge = ev_b;
         res      = mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      end else if (ev_s <= ev_d && ev_s <= TMO) begin
         res_edge = ev_s;
         res      = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      end else if (ev_d <= TMO) begin
         a0       = (d0 < NEVER) && (d0 <= dmin + 1);
         a1       = (d1 < NEVER) && (d1 <= dmin + 1);
         res_edge = ev_d + 1;
         res      = mk(1'b1, 1'b1, {a1, a0}, 1'b1, 1'b0);
      end else begin
         res_edge = TMO;
         res      = mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
      end
   endfunction

   task automatic tick();
      @(posedge BCLK);
      #1;
   endtask

   task automatic start_cycle();
      CYCLE_START = 1'b1;
      tick();
      CYCLE_START = 1'b0;
   endtask

   task automatic end_cycle();
      CYCLE_END = 1'b1;
      tick();
      CYCLE_END = 1'b0;
   endtask

   task automatic release_all();
      DSACK0_   = 1'b1;
      DSACK1_   = 1'b1;
      STERM_IN_ = 1'b1;
      BERR_IN_  = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      CCRESET_    = 1'b0;
      DSACK0_     = 1'b1;
      DSACK1_     = 1'b1;
      STERM_IN_   = 1'b1;
      BERR_IN_    = 1'b1;
      CYCLE_START = 1'b0;
      CYCLE_END   = 1'b0;
      repeat (2) tick();
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL reset_hold: got %b expected %b", outs(), CLR);
      end
      CCRESET_ = 1'b1;
      repeat (2) tick();
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL reset_release: got %b expected %b", outs(), CLR);
      end
   endtask

   task automatic test_dsack32();
      logic [5:0] exp;
      start_cycle();
      repeat (2) tick();
      DSACK0_ = 1'b0;
      DSACK1_ = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = (k >= 4) ? mk(1'b1, 1'b1, 2'b11, 1'b1, 1'b0) : CLR;
         total++;
         if (outs() !== exp) begin
            bad++;
            $display("FAIL dsack32 tick%0d: got %b expected %b", k, outs(), exp);
         end
      end
      end_cycle();
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL dsack32_end: got %b expected %b", outs(), CLR);
      end
      release_all();
   endtask

   task automatic test_skew();
      logic [5:0] exp;
      logic [1:0] port;
      for (int skew = 1; skew <= 2; skew++) begin
         port = (skew == 1) ? 2'b11 : 2'b01;
         start_cycle();
         DSACK0_ = 1'b0;
         for (int k = 0; k < 7; k++) begin
            if (k == skew) DSACK1_ = 1'b0;
            tick();
            exp = (k + 1 >= 4) ? mk(1'b1, 1'b1, port, 1'b1, 1'b0) : CLR;
            total++;
            if (outs() !== exp) begin
               bad++;
               $display("FAIL skew%0d tick%0d: got %b expected %b", skew, k + 1, outs(), exp);
            end
         end
         end_cycle();
         release_all();
      end
   endtask

   task automatic test_sterm_priority();
      logic [5:0] exp;
      start_cycle();
      STERM_IN_ = 1'b0;
      DSACK0_   = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp = (k >= 2) ? mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0) : CLR;
         total++;
         if (outs() !== exp) begin
            bad++;
            $display("FAIL sterm_prio tick%0d: got %b expected %b", k, outs(), exp);
         end
      end
      end_cycle();
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL sterm_end: got %b expected %b", outs(), CLR);
      end
      release_all();
   endtask

   task automatic test_timeout();
      logic [5:0] exp;
      start_cycle();
      for (int k = 1; k <= TMO + 2; k++) begin
         tick();
         exp = (k >= TMO) ? mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1) : CLR;
         total++;
         if (outs() !== exp) begin
            bad++;
            $display("FAIL timeout edge%0d: got %b expected %b", k, outs(), exp);
         end
      end
      end_cycle();
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL timeout_end: got %b expected %b", outs(), CLR);
      end
      release_all();
   endtask

   task automatic test_berr();
      logic [5:0] exp;
      start_cycle();
      BERR_IN_ = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp = (k >= 3) ? mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b0) : CLR;
         total++;
         if (outs() !== exp) begin
            bad++;
            $display("FAIL berr tick%0d: got %b expected %b", k, outs(), exp);
         end
      end
      end_cycle();
      release_all();
   endtask

   task automatic test_settle_abort();
      logic [5:0] exp;
      start_cycle();
      DSACK0_ = 1'b0;
      for (int k = 1; k <= TMO + 1; k++) begin
         tick();
         DSACK0_ = 1'b1;
         exp = (k >= TMO) ? mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1) : CLR;
         total++;
         if (outs() !== exp) begin
            bad++;
            $display("FAIL settle_abort edge%0d: got %b expected %b", k, outs(), exp);
         end
      end
      end_cycle();
      release_all();
   endtask

   task automatic test_reset_settle();
      start_cycle();
      DSACK0_ = 1'b0;
      DSACK1_ = 1'b0;
      repeat (3) tick();
      #2 CCRESET_ = 1'b0;
      #1;
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL rst_in_settle: got %b expected %b", outs(), CLR);
      end
      tick();
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL rst_hold_settle: got %b expected %b", outs(), CLR);
      end
      CCRESET_ = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if (outs() !== CLR) begin
            bad++;
            $display("FAIL rst_release tick%0d: got %b expected %b", k, outs(), CLR);
         end
      end
      release_all();
      // Reset must clear a held termination without waiting for a clock
      start_cycle();
      DSACK0_ = 1'b0;
      repeat (4) tick();
      total++;
      if (outs() !== mk(1'b1, 1'b1, 2'b01, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL pre_rst_term: got %b expected %b", outs(), mk(1'b1, 1'b1, 2'b01, 1'b1, 1'b0));
      end
      #2 CCRESET_ = 1'b0;
      #1;
      total++;
      if (outs() !== CLR) begin
         bad++;
         $display("FAIL rst_async_term: got %b expected %b", outs(), CLR);
      end
      #2 CCRESET_ = 1'b1;
      release_all();
   endtask

   task automatic test_start_end_together();
      logic [5:0] exp;
      start_cycle();
      STERM_IN_ = 1'b0;
      repeat (2) tick();
      STERM_IN_ = 1'b1;
      total++;
      if (outs() !== mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL pair_pre: got %b expected %b", outs(), mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
      end
      CYCLE_START = 1'b1;
      CYCLE_END   = 1'b1;
      tick();
      CYCLE_START = 1'b0;
      CYCLE_END   = 1'b0;
      // Back in IDLE: no timeout may follow
      for (int k = 1; k <= TMO + 3; k++) begin
         total++;
         if (outs() !== CLR) begin
            bad++;
            $display("FAIL pair_term edge%0d: got %b expected %b", k, outs(), CLR);
         end
         tick();
      end
      // Same pair in IDLE starts a cycle, observable through the timeout
      CYCLE_START = 1'b1;
      CYCLE_END   = 1'b1;
      tick();
      CYCLE_START = 1'b0;
      CYCLE_END   = 1'b0;
      for (int k = 1; k <= TMO; k++) begin
         tick();
         exp = (k >= TMO) ? mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1) : CLR;
         total++;
         if (outs() !== exp) begin
            bad++;
            $display("FAIL pair_idle edge%0d: got %b expected %b", k, outs(), exp);
         end
      end
      end_cycle();
      release_all();
   endtask

   task automatic test_idle_ignore();
      DSACK0_   = 1'b0;
      DSACK1_   = 1'b0;
      STERM_IN_ = 1'b0;
      BERR_IN_  = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if (outs() !== CLR) begin
            bad++;
            $display("FAIL idle_ignore tick%0d: got %b expected %b", k, outs(), CLR);
         end
      end
      release_all();
   endtask

   task automatic test_random();
      int d[4];
      int res_edge;
      logic [5:0] res;
      logic [5:0] exp;
      for (int it = 0; it < 24; it++) begin
         for (int j = 0; j < 4; j++) begin
            d[j] = ($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(0, 15));
         end
         predict(d[0], d[1], d[2], d[3], res_edge, res);
         start_cycle();
         for (int k = 0; k < 20; k++) begin
            if (d[0] == k) BERR_IN_  = 1'b0;
            if (d[1] == k) STERM_IN_ = 1'b0;
            if (d[2] == k) DSACK0_   = 1'b0;
            if (d[3] == k) DSACK1_   = 1'b0;
            tick();
            exp = (k + 1 >= res_edge) ? res : CLR;
            total++;
            if (outs() !== exp) begin
               bad++;
               $display("FAIL rand%0d edge%0d: got %b expected %b (berr@%0d sterm@%0d ds0@%0d ds1@%0d)",
                        it, k + 1, outs(), exp, d[0], d[1], d[2], d[3]);
            end
         end
         end_cycle();
         total++;
         if (outs() !== CLR) begin
            bad++;
            $display("FAIL rand%0d_end: got %b expected %b", it, outs(), CLR);
         end
         release_all();
      end
   endtask

   initial begin
      test_reset();
      test_dsack32();
      test_skew();
      test_sterm_priority();
      test_timeout();
      test_berr();
      test_settle_abort();
      test_reset_settle();
      test_start_end_together();
      test_idle_ignore();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1);
   end

endmodule
